float_to_fixed_pipe: RTL and testbench

Pipelined, parametrised IEEE-754 single-precision to signed fixed-point converter with valid/ready handshakes on both sides. It generalises the combinational float-to-int path in three ways: configurable output width and fractional bits, selectable rounding, and per-result status flags. It sits between the float datapath (the MAC/activation units) and integer consumers such as the argmax/classifier and LUT indexing. It accepts one conversion per cycle under no backpressure.

---
 rtl/fp_pkg.sv | 13 +
 rtl/fp_align.sv | 53 +++++
 rtl/float_to_fixed_pipe.sv | 102 ++++++++++
 tb/tb_float_to_fixed_pipe.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: IEEE-754 single-precision field layout, rounding modes and operand classes.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;
  typedef enum logic {RND_TRUNC, RND_RNE} rnd_mode_e;
  typedef enum logic [1:0] {FP_NORM, FP_ZERO, FP_INF, FP_NAN} fp_class_e;
endpackage

// File: rtl/fp_align.sv
// fp_align: classifies a float and aligns its significand to the fixed-point grid with guard/sticky.
module fp_align
  import fp_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 0
) (
  input  logic [31:0]  fp_in,
  output fp_class_e    cls,
  output logic         sign,
  output logic [OUT_W:0] mag,
  output logic         guard,
  output logic         sticky
);
  fp32_t              f;
  logic signed [10:0] k;
  logic [10:0]        sh;
  logic [63:0]        base;
  logic [63:0]        shd;
  // Significand sits at bit 25 so a right shift leaves guard at bit 24 and sticky below it.
  always_comb begin
    f = fp32_t'(fp_in);
    k = 11'(f.exp) - 11'(BIAS + MANT_W) + 11'(FRAC_W);
    sh = k[10] ? 11'(-k) : 11'(k);
    base = {15'b0, 1'b1, f.mant, 25'b0};
    shd = k[10] ? base >> sh : base << sh;
    sign = f.sign;
    cls = FP_NORM;
    mag = shd[25+OUT_W:25];
    guard = shd[24];
    sticky = |shd[23:0];
    if (&f.exp) begin
      cls = |f.mant ? FP_NAN : FP_INF;
      mag = '0;
      guard = 1'b0;
      sticky = 1'b0;
    end else if (!(|f.exp)) begin
      cls = FP_ZERO;
      mag = '0;
      guard = 1'b0;
      sticky = |f.mant;
    end else if (k >= $signed(11'(OUT_W - MANT_W))) begin
      cls = FP_INF;
      mag = '0;
      guard = 1'b0;
      sticky = 1'b0;
    end else if (k < -11'sd25) begin
      mag = '0;
      guard = 1'b0;
      sticky = 1'b1;
    end
  end
endmodule

// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: two-stage float to signed fixed-point converter with valid/ready on both sides.
module float_to_fixed_pipe
  import fp_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [31:0]      fp_in,
  input  logic             rnd_mode,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [OUT_W-1:0] fx_out,
  output logic             ovf,
  output logic             nan,
  output logic             inexact
);
  localparam logic [OUT_W:0]   LIM_NEG = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W:0]   LIM_POS = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  fp_class_e        a_cls, s1_cls_d, s1_cls_q;
  rnd_mode_e        s1_rnd_d, s1_rnd_q;
  logic             a_sign, a_guard, a_sticky;
  logic [OUT_W:0]   a_mag, s1_mag_d, s1_mag_q, rmag;
  logic             s1_vld_d, s1_vld_q, s2_vld_d, s2_vld_q;
  logic             s1_sign_d, s1_sign_q, s1_g_d, s1_g_q, s1_s_d, s1_s_q;
  logic [OUT_W-1:0] fx_d, fx_q, res;
  logic             ovf_d, ovf_q, nan_d, nan_q, inexact_d, inexact_q;
  logic             adv1, adv2, ld1, ld2, inc, sat, is_nan;
  fp_align #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) u_align (
    .fp_in  (fp_in),
    .cls    (a_cls),
    .sign   (a_sign),
    .mag    (a_mag),
    .guard  (a_guard),
    .sticky (a_sticky)
  );
  always_comb begin
    adv2 = !s2_vld_q || out_rdy;
    adv1 = !s1_vld_q || adv2;
    in_rdy = adv1;
    ld1 = adv1 && in_vld;
    ld2 = adv2 && s1_vld_q;
    s1_vld_d = adv1 ? in_vld : s1_vld_q;
    s2_vld_d = adv2 ? s1_vld_q : s2_vld_q;
    s1_cls_d = ld1 ? a_cls : s1_cls_q;
    s1_sign_d = ld1 ? a_sign : s1_sign_q;
    s1_mag_d = ld1 ? a_mag : s1_mag_q;
    s1_g_d = ld1 ? a_guard : s1_g_q;
    s1_s_d = ld1 ? a_sticky : s1_s_q;
    s1_rnd_d = ld1 ? rnd_mode_e'(rnd_mode) : s1_rnd_q;
    inc = (s1_rnd_q == RND_RNE) && s1_g_q && (s1_s_q || s1_mag_q[0]);
    rmag = s1_mag_q + (OUT_W+1)'(inc);
    // Negative side may reach exactly -2^(OUT_W-1) without saturating.
    sat = (s1_cls_q == FP_INF) || (rmag > (s1_sign_q ? LIM_NEG : LIM_POS));
    is_nan = s1_cls_q == FP_NAN;
    res = is_nan ? '0 : sat ? (s1_sign_q ? MIN_NEG : MAX_POS)
        : (s1_sign_q ? -rmag[OUT_W-1:0] : rmag[OUT_W-1:0]);
    fx_d = ld2 ? res : fx_q;
    ovf_d = ld2 ? sat && !is_nan : ovf_q;
    nan_d = ld2 ? is_nan : nan_q;
    inexact_d = ld2 ? !sat && !is_nan && (s1_g_q || s1_s_q) : inexact_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_cls_q <= FP_ZERO;
      s1_sign_q <= 1'b0;
      s1_mag_q <= '0;
      s1_g_q <= 1'b0;
      s1_s_q <= 1'b0;
      s1_rnd_q <= RND_TRUNC;
      fx_q <= '0;
      ovf_q <= 1'b0;
      nan_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s1_cls_q <= s1_cls_d;
      s1_sign_q <= s1_sign_d;
      s1_mag_q <= s1_mag_d;
      s1_g_q <= s1_g_d;
      s1_s_q <= s1_s_d;
      s1_rnd_q <= s1_rnd_d;
      fx_q <= fx_d;
      ovf_q <= ovf_d;
      nan_q <= nan_d;
      inexact_q <= inexact_d;
    end
  end
  assign out_vld = s2_vld_q;
  assign fx_out = fx_q;
  assign ovf = ovf_q;
  assign nan = nan_q;
  assign inexact = inexact_q;
endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// tb_float_to_fixed_pipe: directed vectors for Q32.0 and Q8.8 instances plus stall and reset sequences.
module tb_float_to_fixed_pipe;
  logic        clk, rst, in_vld, rnd_mode, out_rdy;
  logic [31:0] fp_in;
  logic        in_rdy, out_vld, ovf, nan, inexact;
  logic [31:0] fx_out;
  logic        in_rdy16, out_vld16, ovf16, nan16, inexact16;
  logic [15:0] fx16;
  int          n_vec, n_bad;
  int          first_in, first_out, last_out;
  bit          saw_stall;

  typedef struct packed {
    bit          w16;
    logic [31:0] fp;
    bit          rnd;
    logic [31:0] fx;
    bit          ovf;
    bit          nan;
    bit          inx;
  } vec_t;

  vec_t        vecs [25];
  logic [31:0] ints [8];

  float_to_fixed_pipe #(.OUT_W(32), .FRAC_W(0)) dut32 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .fp_in(fp_in),
    .rnd_mode(rnd_mode), .out_vld(out_vld), .out_rdy(out_rdy), .fx_out(fx_out),
    .ovf(ovf), .nan(nan), .inexact(inexact)
  );
  float_to_fixed_pipe #(.OUT_W(16), .FRAC_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy16), .fp_in(fp_in),
    .rnd_mode(rnd_mode), .out_vld(out_vld16), .out_rdy(out_rdy), .fx_out(fx16),
    .ovf(ovf16), .nan(nan16), .inexact(inexact16)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    in_vld = 1'b1; fp_in = v.fp; rnd_mode = v.rnd; out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    if (v.w16)
      check($sformatf("vec%0d_q8", idx), {out_vld16, ovf16, nan16, inexact16, 16'h0, fx16},
            {1'b1, v.ovf, v.nan, v.inx, v.fx});
    else
      check($sformatf("vec%0d_q0", idx), {out_vld, ovf, nan, inexact, fx_out},
            {1'b1, v.ovf, v.nan, v.inx, v.fx});
  endtask

  // Streams 1.0..8.0 through the Q32.0 instance, dropping out_rdy on cycles [lo,hi).
  task automatic run_stream(input int lo, input int hi);
    int sent, got;
    sent = 0; got = 0; saw_stall = 1'b0;
    first_in = -1; first_out = -1; last_out = -1;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_rdy = !(cyc >= lo && cyc < hi);
      in_vld = sent < 8;
      fp_in = sent < 8 ? ints[sent] : 32'h0;
      rnd_mode = 1'b0;
      #1;
      if (!in_rdy) saw_stall = 1'b1;
      if (out_vld) begin
        check(out_rdy ? "stream_out" : "stream_hold", 36'(fx_out), 36'(got + 1));
        if (out_rdy) begin
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
          got++;
        end
      end
      if (in_vld && in_rdy) begin
        if (first_in < 0) first_in = cyc;
        sent++;
      end
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    check("stream_count", 36'(got), 36'd8);
  endtask

  initial begin
    vecs = '{
      '{1'b0, 32'h40490FDB, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h3FC00000, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h40200000, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'hCF000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0},
      '{1'b0, 32'h4F000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0},
      '{1'b0, 32'hFF800000, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0},
      '{1'b0, 32'h7FC00000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0},
      '{1'b0, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0},
      '{1'b0, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h3FC00000, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'hBFC00000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h3F000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h3F400000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1},
      '{1'b0, 32'h40400000, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0},
      '{1'b0, 32'hCF000001, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0},
      '{1'b0, 32'h4EFFFFFF, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0, 1'b0},
      '{1'b0, 32'h7F800000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0},
      '{1'b1, 32'h3FA00000, 1'b1, 32'h00000140, 1'b0, 1'b0, 1'b0},
      '{1'b1, 32'hBF800000, 1'b1, 32'h0000FF00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 32'h43000000, 1'b1, 32'h00007FFF, 1'b1, 1'b0, 1'b0},
      '{1'b1, 32'hC3000000, 1'b1, 32'h00008000, 1'b0, 1'b0, 1'b0},
      '{1'b1, 32'h3B800000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0},
      '{1'b1, 32'h3B000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1},
      '{1'b1, 32'h3B400000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b1}
    };
    ints = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    n_vec = 0; n_bad = 0;
    clk = 1'b0; rst = 1'b1; in_vld = 1'b0; fp_in = '0; rnd_mode = 1'b0; out_rdy = 1'b1;
    #12;
    check("reset_state", {out_vld, ovf, nan, inexact, fx_out}, 36'h0);
    check("reset_in_rdy", 36'(in_rdy), 36'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) apply_vec(i);

    run_stream(-1, -1);
    check("latency", 36'(first_out - first_in), 36'd2);
    check("throughput", 36'(last_out - first_out), 36'd7);
    check("no_stall", 36'(saw_stall), 36'd0);

    run_stream(3, 8);
    check("in_rdy_drop", 36'(saw_stall), 36'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_dup", 36'(out_vld), 36'd0);
    end

    @(negedge clk);
    out_rdy = 1'b0; in_vld = 1'b1; fp_in = 32'h40490FDB; rnd_mode = 1'b0;
    @(negedge clk);
    fp_in = 32'h40400000;
    @(negedge clk);
    in_vld = 1'b0;
    check("pre_rst", {out_vld, ovf, nan, inexact, fx_out}, {4'b1001, 32'd3});
    check("pre_rst_full", 36'(in_rdy), 36'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {out_vld, ovf, nan, inexact, fx_out}, 36'h0);
    check("async_rst_rdy", 36'(in_rdy), 36'd1);
    @(negedge clk);
    rst = 1'b0; out_rdy = 1'b1; in_vld = 1'b1; fp_in = 32'h40A00000;
    @(negedge clk);
    in_vld = 1'b0;
    check("rst_lat1", 36'(out_vld), 36'd0);
    @(negedge clk);
    check("rst_lat2", {out_vld, ovf, nan, inexact, fx_out}, {4'b1000, 32'd5});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
